seq_divider: RTL and testbench
==============================

# seq_divider

Multicycle radix-2 restoring divider serving the execute-stage ALU's DIV/DIVU instructions. It accepts a one-cycle start pulse with dividend and divisor and raises Stall while computing. When Stall drops it presents a held Quotient/Remainder pair, which the ALU commits to HILO. Signed operation uses magnitude division with a final sign-correction cycle.

## Interface
- WIDTH, 32, operand/result width; the counter width is derived as clog2(WIDTH)+1.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- OP_div  input  1  start signed divide; sampled only when idle.
- OP_divu  input  1  start unsigned divide; sampled only when idle.
- Dividend  input  WIDTH  numerator; sampled on the start edge only.
- Divisor  input  WIDTH  denominator; sampled on the start edge only.
- Quotient  output  WIDTH  registered quotient; held until the next completion.
- Remainder  output  WIDTH  registered remainder; held until the next completion.
- Stall  output  1  high while a divide is in progress; equals (state != IDLE).

## Operation
- States and transitions:
  - IDLE: moves to RUN on an edge where OP_div or OP_divu is high.
  - RUN: performs exactly WIDTH iterations, then moves to FIX.
  - FIX: moves to IDLE unconditionally.
- Start edge:
  - Latch signedness. OP_div has priority if both start inputs are high.
  - Latch neg_q = signed & (Dividend[MSB] ^ Divisor[MSB]) and neg_r = signed & Dividend[MSB].
  - Load the magnitudes. Absolute value is applied only when signed.
  - Clear the partial remainder. Set count = WIDTH.
- RUN iteration:
  - trial = {rem[WIDTH-2:0], quo[MSB]} - divisor_mag, computed in WIDTH+1 bits.
  - If trial is non-negative: rem = trial[WIDTH-1:0] and shift 1 into quo.
  - Otherwise: rem shifts left with quo[MSB], and 0 is shifted into quo.
  - Decrement count. Leave RUN when count reaches 1 and that iteration completes.
- FIX:
  - Quotient = neg_q ? -quo : quo.
  - Remainder = neg_r ? -rem : rem.
  - Result: quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: no special case. The algorithm result is architecturally defined.
  - Unsigned: Quotient = all ones, Remainder = Dividend.
  - Signed: the magnitude result is followed by normal sign correction.
- Signed most-negative / -1: Quotient = 0x8000_0000, Remainder = 0. No exception.
- Start pulses while Stall is high are ignored. Operands are not re-sampled.
- Quotient and Remainder update only on the FIX edge. They never show intermediate values.

## Timing
- Reset (asynchronous, active-low):
  - State = IDLE; Stall = 0.
  - Quotient = 0, Remainder = 0.
  - All internal registers are cleared.
- Reset asserted mid-divide aborts immediately. No partial result reaches the outputs.
- Latency, with the start sampled at edge E0:
  - Stall is 1 from after E0 through E0+WIDTH+1.
  - Results become valid, and Stall falls, after edge E0+WIDTH+1.
  - For WIDTH=32, Stall is high for 33 cycles.
- In the cycle Stall first reads 0 after a divide, Quotient and Remainder are already final. The ALU commits on that edge.
- Back-to-back: a new start is accepted on the first edge where Stall is 0, i.e. the edge right after results appear. Results stay held until that divide's FIX edge.
- Operand inputs are don't-care except on the start edge.

## Structure
- Shared package holds:
  - State encoding localparams: IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2.
  - The default WIDTH constant.
- Single module; no sub-module is needed. The conditional negate is a local function used for both the input magnitudes and the output correction.
- Estimated size: about 150–200 lines of RTL.

## Test plan
- Unsigned: OP_divu, 100 / 7 → after 33 Stall cycles, Quotient = 14 and Remainder = 2; Stall = 0.
- Signed: OP_div, -7 / 2 → Quotient = 0xFFFF_FFFD and Remainder = 0xFFFF_FFFF. Also 7 / -2 → Quotient = 0xFFFF_FFFD and Remainder = 1.
- Edge operands:
  - OP_div, 0x8000_0000 / 0xFFFF_FFFF → Quotient = 0x8000_0000, Remainder = 0.
  - OP_divu, 0x1234 / 0 → Quotient = 0xFFFF_FFFF, Remainder = 0x1234.
- Busy start ignored: start 50 / 5 unsigned; at cycle 10 pulse OP_div with 9 / 3 → final result Quotient = 10, Remainder = 0, and Stall falls exactly 33 cycles after the first start.
- Reset mid-op: assert reset at cycle 15 of a divide → Stall, Quotient and Remainder drop to 0 asynchronously. After release a fresh 81 / 9 unsigned gives Quotient = 9, Remainder = 0.
- Back-to-back: issue a second start on the first Stall-low edge → first results stay held during the whole second divide; Stall is high again for exactly 33 cycles.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and default width for the sequential divider
package seq_divider_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider with magnitude division and a final sign-correction cycle
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall
);
    localparam int CW = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] cneg(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    logic [1:0]       state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic             neg_q, neg_r;
    logic [WIDTH:0]   trial;

    // rem's top bit is kept so divisors at or above 2^(WIDTH-1) still restore correctly
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        if (state == IDLE) next_state = (OP_div | OP_divu) ? RUN : IDLE;
        else if (state == RUN) next_state = (cnt == CW'(1)) ? FIX : RUN;
    end

    always_comb Stall = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
        end else if (state == IDLE) begin
            if (OP_div | OP_divu) begin
                neg_q <= OP_div & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                neg_r <= OP_div & Dividend[WIDTH-1];
                quo   <= cneg(OP_div & Dividend[WIDTH-1], Dividend);
                dvs   <= cneg(OP_div & Divisor[WIDTH-1], Divisor);
                rem   <= '0;
                cnt   <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt - CW'(1);
        end else begin
            Quotient  <= cneg(neg_q, quo);
            Remainder <= cneg(neg_r, rem);
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a queue scoreboard checked on every Stall falling edge
module tb_seq_divider;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        OP_div = 1'b0;
    logic        OP_divu = 1'b0;
    logic [31:0] Dividend = '0;
    logic [31:0] Divisor = '0;
    logic [31:0] Quotient, Remainder;
    logic        Stall;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .OP_div(OP_div),
        .OP_divu(OP_divu),
        .Dividend(Dividend),
        .Divisor(Divisor),
        .Quotient(Quotient),
        .Remainder(Remainder),
        .Stall(Stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // called at a negedge; returns at the following negedge with the start already sampled
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic push);
        exp_t e;
        OP_div   = sgn;
        OP_divu  = ~sgn;
        Dividend = a;
        Divisor  = b;
        if (push) begin
            e.q = eq;
            e.r = er;
            sb.push_back(e);
        end
        @(negedge clock);
        OP_div   = 1'b0;
        OP_divu  = 1'b0;
        Dividend = 32'hDEAD_BEEF;
        Divisor  = 32'hCAFE_F00D;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!Stall) return;
            @(negedge clock);
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: Stall still high after 100 cycles");
    endtask

    initial begin
        logic        prev = 1'b0;
        int          scnt = 0;
        logic [31:0] hq = '0;
        logic [31:0] hr = '0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev = 1'b0;
                scnt = 0;
                hq   = '0;
                hr   = '0;
            end else begin
                if (prev && !Stall) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: q=%h r=%h", Quotient, Remainder);
                    end else begin
                        e = sb.pop_front();
                        chk("quotient", Quotient, e.q);
                        chk("remainder", Remainder, e.r);
                        chk("stall_cycles", 32'(scnt), 32'd33);
                        hq = e.q;
                        hr = e.r;
                    end
                    scnt = 0;
                end else begin
                    if (Stall) scnt++;
                    chk("hold_q", Quotient, hq);
                    chk("hold_r", Remainder, hr);
                end
                prev = Stall;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_q", Quotient, 32'd0);
        chk("rst_r", Remainder, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        wait_idle();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b1);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
        wait_idle();
        issue(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b1);
        wait_idle();
        // start while busy must be ignored
        issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b1);
        repeat (8) @(negedge clock);
        OP_div   = 1'b1;
        Dividend = 32'd9;
        Divisor  = 32'd3;
        @(negedge clock);
        OP_div = 1'b0;
        wait_idle();
        // reset in the middle of a divide
        issue(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
        repeat (14) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort_stall", 32'(Stall), 32'd0);
        chk("abort_q", Quotient, 32'd0);
        chk("abort_r", Remainder, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        issue(1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b1);
        wait_idle();
        // back-to-back on the first Stall-low edge
        issue(1'b0, 32'd200, 32'd10, 32'd20, 32'd0, 1'b1);
        wait_idle();
        issue(1'b0, 32'd17, 32'd5, 32'd3, 32'd2, 1'b1);
        wait_idle();
        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
